ula_sequencial: RTL and testbench

ULA_SEQUENCIAL -- requirements
Module: ula_sequencial

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_sequencial_if.sv | 25 ++
 rtl/mul_div_iterativo.sv | 69 ++++++
 rtl/ula_sequencial.sv | 104 ++++++++++
 tb/tb_ula_sequencial.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared opcode encodings, FSM state type and iterative-unit mode for the sequential ALU.
package ula_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_MUL  = 4'd7,
    OP_DIVU = 4'd8,
    OP_REMU = 4'd9
  } opcode_t;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULANDO,
    PRONTO
  } estado_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } modo_t;

endpackage

// File: rtl/ula_sequencial_if.sv
// Request/result bundle of the sequential ALU; the requester is master, the ALU is slave.
interface ula_sequencial_if #(parameter int BITS = 64);
  logic            inicio;
  logic [BITS-1:0] dina;
  logic [BITS-1:0] dinb;
  logic [BITS-1:0] imm;
  logic            alu_src;
  logic [3:0]      operacao;
  logic [BITS-1:0] dout;
  logic            ocupado;
  logic            pronto;
  logic            flag_maior_igual_u;
  logic            flag_igual;
  logic            flag_menor;

  modport master (
    output inicio, dina, dinb, imm, alu_src, operacao,
    input  dout, ocupado, pronto, flag_maior_igual_u, flag_igual, flag_menor
  );

  modport slave (
    input  inicio, dina, dinb, imm, alu_src, operacao,
    output dout, ocupado, pronto, flag_maior_igual_u, flag_igual, flag_menor
  );
endinterface

// File: rtl/mul_div_iterativo.sv
// One-bit-per-cycle shift-add multiplier / restoring divider; runs exactly BITS steps after start.
module mul_div_iterativo
  import ula_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  modo_t           modo,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            ultimo,
  output logic [BITS-1:0] resultado
);
  localparam int CW = $clog2(BITS) + 1;

  // MUL: acc = partial product, sh_a = multiplicand, sh_b = multiplier.
  // DIV: acc = remainder, sh_a = dividend shifting into quotient, sh_b = divisor.
  logic [CW-1:0]   cnt;
  modo_t           modo_r;
  logic [BITS-1:0] acc, sh_a, sh_b;
  logic [BITS-1:0] acc_n, sh_a_n, sh_b_n;
  logic [BITS:0]   trial, diff;

  always_comb begin
    acc_n  = acc;
    sh_a_n = sh_a;
    sh_b_n = sh_b;
    trial  = {acc, sh_a[BITS-1]};
    diff   = trial - {1'b0, sh_b};
    if (modo_r == MD_MUL) begin
      acc_n  = acc + (sh_b[0] ? sh_a : '0);
      sh_a_n = sh_a << 1;
      sh_b_n = sh_b >> 1;
    end else if (!diff[BITS]) begin
      acc_n  = diff[BITS-1:0];
      sh_a_n = {sh_a[BITS-2:0], 1'b1};
    end else begin
      acc_n  = trial[BITS-1:0];
      sh_a_n = {sh_a[BITS-2:0], 1'b0};
    end
  end

  // The result reflects the step being taken this cycle, so the owner can register it on the last edge.
  assign resultado = (modo_r == MD_DIVU) ? sh_a_n : acc_n;
  assign ultimo    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      modo_r <= MD_MUL;
      acc    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
    end else if (start) begin
      cnt    <= CW'(BITS);
      modo_r <= modo;
      acc    <= '0;
      sh_a   <= a;
      sh_b   <= b;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      acc  <= acc_n;
      sh_a <= sh_a_n;
      sh_b <= sh_b_n;
    end
  end
endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU under a 3-state FSM.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int BITS = 64
) (
  input logic             clk,
  input logic             reset,
  ula_sequencial_if.slave bus
);
  estado_t         estado, estado_n;
  logic [BITS-1:0] op_b, res_simples, res_iter;
  logic            aceita, iterativo, div_zero, ultimo;
  logic [2:0]      cmp, cmp_cap;
  modo_t           modo;

  always_comb begin
    op_b        = bus.alu_src ? bus.imm : bus.dinb;
    aceita      = bus.inicio && (estado != CALCULANDO);
    div_zero    = (op_b == '0);
    iterativo   = 1'b0;
    modo        = MD_MUL;
    res_simples = '0;
    case (bus.operacao)
      OP_ADD:  res_simples = bus.dina + op_b;
      OP_SUB:  res_simples = bus.dina - op_b;
      OP_AND:  res_simples = bus.dina & op_b;
      OP_OR:   res_simples = bus.dina | op_b;
      OP_XOR:  res_simples = bus.dina ^ op_b;
      OP_SLT:  res_simples = BITS'($signed(bus.dina) < $signed(op_b));
      OP_SLTU: res_simples = BITS'(bus.dina < op_b);
      OP_MUL: begin
        iterativo = 1'b1;
        modo      = MD_MUL;
      end
      OP_DIVU: begin
        if (div_zero) res_simples = '1;
        else begin
          iterativo = 1'b1;
          modo      = MD_DIVU;
        end
      end
      OP_REMU: begin
        if (div_zero) res_simples = bus.dina;
        else begin
          iterativo = 1'b1;
          modo      = MD_REMU;
        end
      end
      default: res_simples = '0;
    endcase
    cmp = {bus.dina >= bus.dinb, bus.dina == bus.dinb, $signed(bus.dina) < $signed(bus.dinb)};
  end

  always_comb begin
    estado_n = estado;
    case (estado)
      OCIOSO, PRONTO: begin
        if (aceita) estado_n = iterativo ? CALCULANDO : PRONTO;
        else        estado_n = OCIOSO;
      end
      CALCULANDO: if (ultimo) estado_n = PRONTO;
      default:    estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_n;
  end

  // Flags are sampled at acceptance but only published at completion, so outputs stay coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout               <= '0;
      bus.flag_maior_igual_u <= 1'b0;
      bus.flag_igual         <= 1'b0;
      bus.flag_menor         <= 1'b0;
      cmp_cap                <= '0;
    end else if (aceita && !iterativo) begin
      bus.dout <= res_simples;
      {bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor} <= cmp;
    end else if (aceita) begin
      cmp_cap <= cmp;
    end else if (estado == CALCULANDO && ultimo) begin
      bus.dout <= res_iter;
      {bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor} <= cmp_cap;
    end
  end

  assign bus.ocupado = (estado == CALCULANDO);
  assign bus.pronto  = (estado == PRONTO);

  mul_div_iterativo #(.BITS(BITS)) u_mul_div (
    .clk       (clk),
    .reset     (reset),
    .start     (aceita && iterativo),
    .modo      (modo),
    .a         (bus.dina),
    .b         (op_b),
    .ultimo    (ultimo),
    .resultado (res_iter)
  );
endmodule

// File: tb/tb_ula_sequencial.sv
// Directed-vector bench for ula_sequencial at BITS=64 with hand-computed expectations.
module tb_ula_sequencial;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   lat, busy;

  ula_sequencial_if #(.BITS(64)) bus ();

  ula_sequencial #(.BITS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for pronto; lat counts cycles from the accepting edge.
  task automatic run(input logic [3:0] opc, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] im, input logic src, input bit mid,
                     output int l, output int bz);
    bus.operacao = opc;
    bus.dina     = a;
    bus.dinb     = b;
    bus.imm      = im;
    bus.alu_src  = src;
    bus.inicio   = 1'b1;
    @(posedge clk) #1;
    bus.inicio = 1'b0;
    l  = -1;
    bz = 0;
    for (int i = 1; i <= 200; i++) begin
      if (bus.pronto) begin
        l = i;
        break;
      end
      if (bus.ocupado) bz++;
      if (mid && i == 10) begin
        bus.operacao = OP_ADD;
        bus.inicio   = 1'b1;
      end
      if (mid && i == 11) bus.inicio = 1'b0;
      @(posedge clk) #1;
    end
  endtask

  initial begin
    bus.inicio   = 1'b0;
    bus.operacao = '0;
    bus.dina     = '0;
    bus.dinb     = '0;
    bus.imm      = '0;
    bus.alu_src  = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout, 64'd0);
    chk("rst_pronto", 64'(bus.pronto), 64'd0);
    chk("rst_ocupado", 64'(bus.ocupado), 64'd0);
    chk("rst_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'd0);
    reset = 1'b0;
    @(posedge clk) #1;

    run(OP_ADD, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_dout", bus.dout, 64'd12);
    chk("add_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'b001);
    @(posedge clk) #1;
    chk("add_pulse_end", 64'(bus.pronto), 64'd0);
    chk("add_hold", bus.dout, 64'd12);

    run(OP_SUB, 64'd3, 64'd3, 64'd5, 1'b1, 1'b0, lat, busy);
    chk("sub_imm", bus.dout, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'b110);
    run(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("slt", bus.dout, 64'd1);
    chk("slt_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'b101);
    run(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("sltu", bus.dout, 64'd0);
    run(OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("and", bus.dout, 64'hF000);
    run(OP_OR, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("or", bus.dout, 64'hFFF0);
    run(OP_XOR, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("xor", bus.dout, 64'h0FF0);
    run(4'd12, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("reserved_lat", 64'(lat), 64'd1);
    chk("reserved", bus.dout, 64'd0);
    @(posedge clk) #1;

    run(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0001, 64'd0, 1'b0, 1'b1, lat, busy);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_busy", 64'(busy), 64'd64);
    chk("mul_dout", bus.dout, 64'h1_0000_0000);
    // Issued during the MUL's pronto cycle: must complete on the very next cycle.
    run(OP_AND, 64'h00FF, 64'h0F0F, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("b2b_lat", 64'(lat), 64'd1);
    chk("b2b_dout", bus.dout, 64'h000F);
    @(posedge clk) #1;

    run(OP_DIVU, 64'd100, 64'd7, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("divu_lat", 64'(lat), 64'd65);
    chk("divu", bus.dout, 64'd14);
    chk("divu_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'b100);
    run(OP_REMU, 64'd100, 64'd7, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("remu_lat", 64'(lat), 64'd65);
    chk("remu", bus.dout, 64'd2);
    run(OP_DIVU, 64'd9, 64'd0, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("divu0_lat", 64'(lat), 64'd1);
    chk("divu0", bus.dout, 64'hFFFF_FFFF_FFFF_FFFF);
    run(OP_REMU, 64'd9, 64'd0, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("remu0_lat", 64'(lat), 64'd1);
    chk("remu0", bus.dout, 64'd9);
    @(posedge clk) #1;

    bus.operacao = OP_DIVU;
    bus.dina     = 64'd1000;
    bus.dinb     = 64'd3;
    bus.alu_src  = 1'b0;
    bus.inicio   = 1'b1;
    @(posedge clk) #1;
    bus.inicio = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.ocupado), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_dout", bus.dout, 64'd0);
    chk("abort_ocupado", 64'(bus.ocupado), 64'd0);
    chk("abort_pronto", 64'(bus.pronto), 64'd0);
    chk("abort_flags", 64'({bus.flag_maior_igual_u, bus.flag_igual, bus.flag_menor}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk) #1;
      if (bus.pronto || bus.ocupado) busy++;
    end
    chk("abort_quiet", 64'(busy), 64'd0);
    run(OP_ADD, 64'd2, 64'd3, 64'd0, 1'b0, 1'b0, lat, busy);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_add", bus.dout, 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
